// File: rtl/main.sv
// Four-vertex store loaded over SPI (mode 0) with a push-button 90-degree rotation about the centroid.
// Optional feature: define MISO_READBACK_EN to shift the stored vertex words back out on MISO.

module main (
    input  logic       clock,
    input  logic       io_aresetn,
    input  logic       io_spi_sclk,
    input  logic       io_spi_cs,
    input  logic       io_spi_mosi,
    output logic       io_spi_miso,
    input  logic [3:0] io_btn,
    output logic       io_led
);

    logic [1:0]        r_sclkSync;
    logic [1:0]        r_csSync;
    logic [1:0]        r_mosiSync;
    logic [1:0]        r_btnSync;
    logic              r_sclkPrev;
    logic              r_csPrev;
    logic              r_btnPrev;

    logic              r_frameActive;
    logic [3:0]        r_bitCnt;
    logic [3:0]        r_wordCnt;
    logic [14:0]       r_shift;
    logic [7:0][15:0]  r_shadow;
    logic              r_commitPending;

    logic              r_rotReq;
    logic              r_led;
    logic [3:0][15:0]  r_vx;
    logic [3:0][15:0]  r_vy;

    logic              w_csLow;
    logic              w_csFall;
    logic              w_sclkRise;
    logic              w_btnRise;
    logic              w_wordDone;
    logic [15:0]       w_word;
    logic [17:0]       w_sumX;
    logic [17:0]       w_sumY;
    logic [15:0]       w_cx;
    logic [15:0]       w_cy;
    logic [3:0][15:0]  w_rotX;
    logic [3:0][15:0]  w_rotY;
    logic              w_unusedBtn;

    assign w_unusedBtn = ^io_btn[3:1];

    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            r_sclkSync <= '0;
            r_csSync   <= '0;
            r_mosiSync <= '0;
            r_btnSync  <= '0;
            r_sclkPrev <= 1'b0;
            r_csPrev   <= 1'b0;
            r_btnPrev  <= 1'b0;
        end else begin
            r_sclkSync <= {r_sclkSync[0], io_spi_sclk};
            r_csSync   <= {r_csSync[0], io_spi_cs};
            r_mosiSync <= {r_mosiSync[0], io_spi_mosi};
            r_btnSync  <= {r_btnSync[0], io_btn[0]};
            r_sclkPrev <= r_sclkSync[1];
            r_csPrev   <= r_csSync[1];
            r_btnPrev  <= r_btnSync[1];
        end
    end

    assign w_csLow    = ~r_csSync[1];
    assign w_csFall   = ~r_csSync[1] & r_csPrev;
    assign w_sclkRise = r_sclkSync[1] & ~r_sclkPrev;
    assign w_btnRise  = r_btnSync[1] & ~r_btnPrev;
    assign w_word     = {r_shift, r_mosiSync[1]};
    assign w_wordDone = w_csLow & r_frameActive & w_sclkRise &
                        (r_bitCnt == 4'd15) & (r_wordCnt < 4'd8);

    // A frame only starts on a seen cs falling edge, so cs held low across reset release is ignored.
    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            r_frameActive   <= 1'b0;
            r_bitCnt        <= '0;
            r_wordCnt       <= '0;
            r_shift         <= '0;
            r_shadow        <= '0;
            r_commitPending <= 1'b0;
        end else begin
            r_commitPending <= w_wordDone && (r_wordCnt == 4'd7);
            if (!w_csLow) begin
                r_frameActive <= 1'b0;
                r_bitCnt      <= '0;
                r_wordCnt     <= '0;
            end else if (w_csFall) begin
                r_frameActive <= 1'b1;
                r_bitCnt      <= '0;
                r_wordCnt     <= '0;
            end else if (r_frameActive && w_sclkRise) begin
                r_shift  <= {r_shift[13:0], r_mosiSync[1]};
                r_bitCnt <= r_bitCnt + 4'd1;
                if (w_wordDone) begin
                    r_shadow[r_wordCnt[2:0]] <= w_word;
                    r_wordCnt                <= r_wordCnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_sumX = '0;
        w_sumY = '0;
        for (int i = 0; i < 4; i++) begin
            w_sumX = w_sumX + {{2{r_vx[i][15]}}, r_vx[i]};
            w_sumY = w_sumY + {{2{r_vy[i][15]}}, r_vy[i]};
        end
    end

    assign w_cx = 16'($signed(w_sumX) >>> 2);
    assign w_cy = 16'($signed(w_sumY) >>> 2);

    // Modular 16-bit arithmetic gives the truncated result directly.
    always_comb begin
        w_rotX = '0;
        w_rotY = '0;
        for (int i = 0; i < 4; i++) begin
            w_rotX[i] = w_cx - (r_vy[i] - w_cy);
            w_rotY[i] = w_cy + (r_vx[i] - w_cx);
        end
    end

    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            r_rotReq <= 1'b0;
            r_led    <= 1'b0;
            r_vx     <= '0;
            r_vy     <= '0;
        end else begin
            r_rotReq <= w_btnRise;
            if (r_commitPending) begin
                r_vx  <= {r_shadow[6], r_shadow[4], r_shadow[2], r_shadow[0]};
                r_vy  <= {r_shadow[7], r_shadow[5], r_shadow[3], r_shadow[1]};
                r_led <= 1'b1;
            end else if (r_rotReq && r_led) begin
                r_vx <= w_rotX;
                r_vy <= w_rotY;
            end
        end
    end

    assign io_led = r_led;

`ifdef MISO_READBACK_EN
    logic         w_sclkFall;
    logic [127:0] r_rdData;
    logic         r_rdArm;
    logic         r_misoOut;

    assign w_sclkFall = ~r_sclkSync[1] & r_sclkPrev;

    // Snapshot at cs fall; first bit appears two cycles later, then one bit per sclk falling edge.
    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            r_rdData  <= '0;
            r_rdArm   <= 1'b0;
            r_misoOut <= 1'b0;
        end else if (!w_csLow) begin
            r_rdArm   <= 1'b0;
            r_misoOut <= 1'b0;
        end else if (w_csFall) begin
            r_rdData <= {r_vx[0], r_vy[0], r_vx[1], r_vy[1],
                         r_vx[2], r_vy[2], r_vx[3], r_vy[3]};
            r_rdArm  <= 1'b1;
        end else if (r_rdArm) begin
            r_misoOut <= r_rdData[127];
            r_rdArm   <= 1'b0;
        end else if (w_sclkFall) begin
            r_rdData  <= {r_rdData[126:0], 1'b0};
            r_misoOut <= r_rdData[126];
        end
    end

    assign io_spi_miso = r_misoOut & ~io_spi_cs;
`else
    assign io_spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_main.sv
// Randomized scoreboard bench for main: SPI frames, aborts, rotations and resets against a behavioural model.
// Readback words are checked against stored vertices when MISO_READBACK_EN is defined, else against 0.

module tb_main;

    logic       clock = 1'b0;
    logic       io_aresetn;
    logic       io_spi_sclk;
    logic       io_spi_cs;
    logic       io_spi_mosi;
    logic       io_spi_miso;
    logic [3:0] io_btn;
    logic       io_led;

    main dut (
        .clock       (clock),
        .io_aresetn  (io_aresetn),
        .io_spi_sclk (io_spi_sclk),
        .io_spi_cs   (io_spi_cs),
        .io_spi_mosi (io_spi_mosi),
        .io_spi_miso (io_spi_miso),
        .io_btn      (io_btn),
        .io_led      (io_led)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] verts;
        logic         led;
    } expT;

    int          testsRun    = 0;
    int          testsFailed = 0;
    expT         expQ[$];
    event        checkEv;
    int          mx[4];
    int          my[4];
    logic        modelLed;
    logic [15:0] frameWords[16];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] packV(input int a, b, c, d, e, f, g, h);
        return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h)};
    endfunction

    function automatic logic [127:0] modelPack();
        logic [127:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[95:0], 16'(mx[i]), 16'(my[i])};
        return r;
    endfunction

    function automatic logic [127:0] dutVerts();
        logic [127:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[95:0], dut.r_vx[i], dut.r_vy[i]};
        return r;
    endfunction

    function automatic int floorDiv4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    function automatic int wrap16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic void modelRotate();
        int cx, cy;
        int nx[4];
        int ny[4];
        if (!modelLed) return;
        cx = floorDiv4(mx[0] + mx[1] + mx[2] + mx[3]);
        cy = floorDiv4(my[0] + my[1] + my[2] + my[3]);
        for (int i = 0; i < 4; i++) begin
            nx[i] = wrap16(cx - (my[i] - cy));
            ny[i] = wrap16(cy + (mx[i] - cx));
        end
        for (int i = 0; i < 4; i++) begin
            mx[i] = nx[i];
            my[i] = ny[i];
        end
    endfunction

    task automatic pushValue(input logic [127:0] v, input logic led);
        expQ.push_back({v, led});
        -> checkEv;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic pushExpect();
        pushValue(modelPack(), modelLed);
    endtask

    task automatic spiWord(input logic [15:0] w, input int nBits, output logic [15:0] rd);
        rd = '0;
        for (int b = 15; b > 15 - nBits; b--) begin
            io_spi_mosi = w[b];
            #40;
            io_spi_sclk = 1'b1;
            rd[b] = io_spi_miso;
            #40;
            io_spi_sclk = 1'b0;
        end
    endtask

    // One cs-low transaction: nWords full words then an optional partial word.
    task automatic applyStimulus(input int nWords, input int partialBits);
        logic [15:0]  rd;
        logic [15:0]  expRd;
        logic [127:0] snap;
        snap = modelPack();
        io_spi_cs = 1'b0;
        #80;
        for (int k = 0; k < nWords; k++) begin
            spiWord(frameWords[k], 16, rd);
            if (k < 8) begin
`ifdef MISO_READBACK_EN
                expRd = snap[127 - 16 * k -: 16];
`else
                expRd = 16'h0;
`endif
                checkOutput($sformatf("readback%0d", k), {112'h0, rd}, {112'h0, expRd});
            end
        end
        if (partialBits > 0) spiWord(frameWords[nWords], partialBits, rd);
        io_spi_mosi = 1'b0;
        #80;
        io_spi_cs = 1'b1;
        #160;
        if (nWords >= 8) begin
            for (int i = 0; i < 4; i++) begin
                mx[i] = int'($signed(frameWords[2 * i]));
                my[i] = int'($signed(frameWords[2 * i + 1]));
            end
            modelLed = 1'b1;
        end
        pushExpect();
    endtask

    task automatic pressButton();
        io_btn = {3'($urandom), 1'b1};
        #100;
        io_btn = {3'($urandom), 1'b0};
        #100;
        modelRotate();
        pushExpect();
    endtask

    task automatic loadSquare();
        frameWords[0] = 16'd0;   frameWords[1] = 16'd0;
        frameWords[2] = 16'd0;   frameWords[3] = 16'd100;
        frameWords[4] = 16'd100; frameWords[5] = 16'd100;
        frameWords[6] = 16'd100; frameWords[7] = 16'd0;
    endtask

    task automatic randomWords();
        for (int k = 0; k < 16; k++)
            frameWords[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
    endtask

    task automatic resetMidFrame();
        logic [15:0] rd;
        randomWords();
        io_spi_cs = 1'b0;
        #80;
        for (int k = 0; k < 3; k++) spiWord(frameWords[k], 16, rd);
        spiWord(frameWords[3], 5, rd);
        io_aresetn = 1'b0;
        #30;
        for (int i = 0; i < 4; i++) begin
            mx[i] = 0;
            my[i] = 0;
        end
        modelLed = 1'b0;
        pushExpect();
        io_spi_cs   = 1'b1;
        io_spi_sclk = 1'b0;
        io_spi_mosi = 1'b0;
        #20;
        io_aresetn = 1'b1;
        #100;
        pushExpect();
    endtask

    // Monitor: pops every queued expectation when signalled and compares against the DUT.
    initial begin
        expT e;
        forever begin
            @(checkEv);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("vertices", dutVerts(), e.verts);
                checkOutput("led", {127'h0, io_led}, {127'h0, e.led});
                checkOutput("misoIdle", {127'h0, io_spi_miso}, 128'h0);
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        io_aresetn  = 1'b0;
        io_spi_sclk = 1'b0;
        io_spi_cs   = 1'b1;
        io_spi_mosi = 1'b0;
        io_btn      = 4'h0;
        for (int i = 0; i < 4; i++) begin
            mx[i] = 0;
            my[i] = 0;
        end
        modelLed = 1'b0;
        repeat (3) @(negedge clock);
        pushValue(128'h0, 1'b0);
        io_aresetn = 1'b1;
        repeat (4) @(negedge clock);

        $display("[TB] rotate before any frame");
        pressButton();

        $display("[TB] square frame and four rotations");
        loadSquare();
        applyStimulus(8, 0);
        pushValue(packV(0, 0, 0, 100, 100, 100, 100, 0), 1'b1);
        pressButton();
        pushValue(packV(100, 0, 0, 0, 0, 100, 100, 100), 1'b1);
        pressButton();
        pushValue(packV(100, 100, 100, 0, 0, 0, 0, 100), 1'b1);
        pressButton();
        pushValue(packV(0, 100, 100, 100, 100, 0, 0, 0), 1'b1);
        pressButton();
        pushValue(packV(0, 0, 0, 100, 100, 100, 100, 0), 1'b1);

        $display("[TB] aborted frames then full frame");
        randomWords();
        applyStimulus(5, 0);
        pushValue(packV(0, 0, 0, 100, 100, 100, 100, 0), 1'b1);
        randomWords();
        applyStimulus(7, 9);
        randomWords();
        applyStimulus(8, 0);

        $display("[TB] resend square frame for readback");
        loadSquare();
        applyStimulus(8, 0);
        applyStimulus(8, 0);

        $display("[TB] reset mid-frame");
        resetMidFrame();
        loadSquare();
        applyStimulus(8, 0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: begin randomWords(); applyStimulus(8, 0); end
                1: pressButton();
                2: begin randomWords(); applyStimulus($urandom_range(0, 7), $urandom_range(0, 15)); end
                default: begin randomWords(); applyStimulus($urandom_range(9, 10), 0); end
            endcase
        end

        repeat (4) @(negedge clock);
        checkOutput("queueDrain", 128'(expQ.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 SHALL have port: clock  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: io_aresetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: io_spi_sclk  input  1  SPI clock from host (mode 0), asynchronous to clock.
REQ-004 SHALL have port: io_spi_cs  input  1  SPI chip select, active-low.
REQ-005 SHALL have port: io_spi_mosi  input  1  SPI data in, MSB first.
REQ-006 SHALL have port: io_spi_miso  output  1  SPI data out, MSB first.
REQ-007 SHALL have port: io_btn  input  4  push buttons, active-high; only bit 0 used (rotate), bits 3:1 ignored.
REQ-008 SHALL have port: io_led  output  1  high when a valid vertex set is stored.
REQ-009 SHALL have no parameters; word width 16, vertex count 4, words per frame 8 are fixed.

Function
REQ-010 SHALL pass io_spi_sclk, io_spi_cs, io_spi_mosi and io_btn[0] through 2-FF synchronizers; SPI edges are detected on the synchronized sclk, and host sclk SHALL be at most clock/8.
REQ-011 SHALL, while synchronized cs is low, shift the synchronized mosi into a 16-bit shift register on each sclk rising edge; 16 bits form one word.
REQ-012 SHALL count words 0..7 per frame; word order is x0,y0,x1,y1,x2,y2,x3,y3, 16-bit two's complement.
REQ-013 SHALL stage received words in a shadow buffer and commit all 8 to the vertex registers in the clock cycle after the 8th word completes; io_led goes high the same cycle.
REQ-014 SHALL reset bit and word counters when synchronized cs is high; a frame with fewer than 8 complete words, or a trailing partial word, is discarded and leaves the vertex registers unchanged.
REQ-015 SHALL ignore words beyond the 8th until cs deasserts.
REQ-016 SHALL detect a 0->1 transition of synchronized io_btn[0] as one rotate request; holding the button generates no further requests.
REQ-017 SHALL, on a rotate request while io_led is high, compute centroid cx=(x0+x1+x2+x3)>>>2, cy likewise (18-bit sum, arithmetic shift, floor), then replace every vertex with x'=cx-(y-cy), y'=cy+(x-cx), truncated to 16 bits, all vertices updated in the same cycle, 1 cycle after the detected edge.
REQ-018 SHALL ignore rotate requests while io_led is low.
REQ-019 SHALL give frame commit priority when commit and rotate update fall in the same cycle; that rotate request is dropped.
REQ-020 SHALL allow rotate while a frame is in progress; the later commit overwrites the result.
REQ-021 SHALL drive io_spi_miso per Configuration; it is 0 whenever cs is high.

Reset
REQ-022 SHALL, while io_aresetn is low, clear vertex registers, shadow buffer, counters and synchronizers to 0, and drive io_led=0 and io_spi_miso=0.
REQ-023 SHALL abandon any frame in progress when reset asserts; after release the next cs falling edge starts word 0.

Configuration
REQ-024 SHALL support macro MISO_READBACK_EN: when defined, during a frame the word shifted out in slot k is the stored vertex word k as of the cs falling edge, MSB first; the first bit is driven 2 cycles after synchronized cs falls, and each next bit is driven on the synchronized sclk falling edge.
REQ-025 SHALL, without MISO_READBACK_EN, tie io_spi_miso to 0 and omit the readback logic.

Verification
REQ-026 SHALL cover: reset, then frame 0,0,0,100,100,100,100,0 -> io_led=1, vertices (0,0),(0,100),(100,100),(100,0).
REQ-027 SHALL cover: after REQ-026, one press of btn[0] -> vertices (100,0),(0,0),(0,100),(100,100); a second press -> (100,100),(100,0),(0,0),(0,100); four presses total -> original order.
REQ-028 SHALL cover: press btn[0] before any frame -> vertices remain 0 and io_led=0.
REQ-029 SHALL cover: frame aborted (cs high) after 5 words -> stored vertices unchanged, and the next full frame commits correctly.
REQ-030 SHALL cover: with MISO_READBACK_EN, after REQ-026 resend the same frame -> MISO returns 0,0,0,100,100,100,100,0, and io_aresetn pulsed low mid-frame -> io_led=0, all vertices 0.
